// File: rtl/cci_mpf_wro_event_counters.sv
// WRO pipeline conflict event counters with a CSR read responder.
// Four saturating counters (rr, rw, wr, ww) are fed from a registered copy
// of the event pulses. Sticky overflow flags record events that are lost to
// saturation. CSR reads complete two cycles after the request and return
// the values as they stood before any same-edge update.
module cci_mpf_wro_event_counters #(
  parameter int COUNTER_WIDTH = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  wro_pipe_events,
  input  logic        csr_rd_en,
  input  logic [2:0]  csr_rd_idx,
  input  logic [8:0]  csr_rd_tid,
  input  logic        csr_wr_clear,
  output logic        csr_rd_valid,
  output logic [63:0] csr_rd_data,
  output logic [8:0]  csr_rd_tid_out
);

  localparam int NUM_CNT = 4;
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [7:0] WIDTH_CODE = 8'(COUNTER_WIDTH);

  localparam logic [2:0] IDX_RR     = 3'd0;
  localparam logic [2:0] IDX_RW     = 3'd1;
  localparam logic [2:0] IDX_WR     = 3'd2;
  localparam logic [2:0] IDX_WW     = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  // Zero-extend a counter value to a full CSR word.
  function automatic logic [63:0] cnt_to_word(input logic [COUNTER_WIDTH-1:0] cnt);
    cnt_to_word = {{(64-COUNTER_WIDTH){1'b0}}, cnt};
  endfunction

  // Status word: overflow flags in the low nibble, counter width in byte 1.
  function automatic logic [63:0] status_word(input logic [3:0] ovf);
    status_word = {48'h0000_0000_0000, WIDTH_CODE, 4'h0, ovf};
  endfunction

  // Event stage
  logic [3:0] ev_q_r;

  // Counter state
  logic [COUNTER_WIDTH-1:0] cnt_r   [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_nxt_s [NUM_CNT];
  logic [3:0]               ovf_r;
  logic [3:0]               ovf_nxt_s;

  // Read pipeline stage 1 (request registered, word snapshotted)
  logic        rd_valid1_r;
  logic [8:0]  rd_tid1_r;
  logic [63:0] rd_word1_r;
  logic [63:0] rd_word_s;

  // Register the raw event pulses; counting happens one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_q_r <= 4'b0000;
    end else begin
      ev_q_r <= wro_pipe_events;
    end
  end

  // Next counter and overflow values: clear wins, otherwise saturating increment.
  always_comb begin
    ovf_nxt_s = ovf_r;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (csr_wr_clear) begin
        cnt_nxt_s[i] = CNT_ZERO;
        ovf_nxt_s[i] = 1'b0;
      end else if (ev_q_r[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          // Event lost to saturation: remember it.
          cnt_nxt_s[i] = cnt_r[i];
          ovf_nxt_s[i] = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
          ovf_nxt_s[i] = ovf_r[i];
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
        ovf_nxt_s[i] = ovf_r[i];
      end
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      ovf_r <= 4'b0000;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      ovf_r <= ovf_nxt_s;
    end
  end

  // Select the requested CSR word from the current (pre-update) state.
  always_comb begin
    rd_word_s = 64'h0000_0000_0000_0000;
    case (csr_rd_idx)
      IDX_RR:     rd_word_s = cnt_to_word(cnt_r[0]);
      IDX_RW:     rd_word_s = cnt_to_word(cnt_r[1]);
      IDX_WR:     rd_word_s = cnt_to_word(cnt_r[2]);
      IDX_WW:     rd_word_s = cnt_to_word(cnt_r[3]);
      IDX_STATUS: rd_word_s = status_word(ovf_r);
      default:    rd_word_s = 64'h0000_0000_0000_0000;
    endcase
  end

  // Read stage 1: accept the request and snapshot the selected word. The
  // index is consumed here, so only the resolved word travels onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid1_r <= 1'b0;
      rd_tid1_r   <= 9'h000;
      rd_word1_r  <= 64'h0000_0000_0000_0000;
    end else if (csr_rd_en) begin
      rd_valid1_r <= 1'b1;
      rd_tid1_r   <= csr_rd_tid;
      rd_word1_r  <= rd_word_s;
    end else begin
      rd_valid1_r <= 1'b0;
      rd_tid1_r   <= 9'h000;
      rd_word1_r  <= 64'h0000_0000_0000_0000;
    end
  end

  // Read stage 2: registered response outputs, held at zero when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_rd_valid   <= 1'b0;
      csr_rd_data    <= 64'h0000_0000_0000_0000;
      csr_rd_tid_out <= 9'h000;
    end else if (rd_valid1_r) begin
      csr_rd_valid   <= 1'b1;
      csr_rd_data    <= rd_word1_r;
      csr_rd_tid_out <= rd_tid1_r;
    end else begin
      csr_rd_valid   <= 1'b0;
      csr_rd_data    <= 64'h0000_0000_0000_0000;
      csr_rd_tid_out <= 9'h000;
    end
  end

endmodule

// File: tb/tb_cci_mpf_wro_event_counters.sv
// Self-checking bench for cci_mpf_wro_event_counters. Two instances
// (COUNTER_WIDTH 48 and 8) share one stimulus stream; a behavioural model
// predicts every response and directed reads pin known literal values.
module tb_cci_mpf_wro_event_counters;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wro_pipe_events = 4'b0000;
  logic        csr_rd_en = 1'b0;
  logic [2:0]  csr_rd_idx = 3'd0;
  logic [8:0]  csr_rd_tid = 9'h000;
  logic        csr_wr_clear = 1'b0;

  logic        v48, v8;
  logic [63:0] d48, d8;
  logic [8:0]  t48, t8;

  int pass_cnt = 0;
  int total_cnt = 0;

  cci_mpf_wro_event_counters u_dut48 (
    .clk(clk), .reset(reset), .wro_pipe_events(wro_pipe_events),
    .csr_rd_en(csr_rd_en), .csr_rd_idx(csr_rd_idx), .csr_rd_tid(csr_rd_tid),
    .csr_wr_clear(csr_wr_clear),
    .csr_rd_valid(v48), .csr_rd_data(d48), .csr_rd_tid_out(t48));

  cci_mpf_wro_event_counters #(.COUNTER_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .wro_pipe_events(wro_pipe_events),
    .csr_rd_en(csr_rd_en), .csr_rd_idx(csr_rd_idx), .csr_rd_tid(csr_rd_tid),
    .csr_wr_clear(csr_wr_clear),
    .csr_rd_valid(v8), .csr_rd_data(d8), .csr_rd_tid_out(t8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [63:0] w48;
    logic [63:0] w8;
    logic [8:0]  tid;
  } resp_t;

  resp_t       exp_q[$];
  int          cyc = 0;
  logic [63:0] m_cnt [2][4];
  logic [3:0]  m_ovf [2];
  logic [3:0]  m_pend;

  function automatic logic [63:0] m_max(input int w);
    m_max = (w == 0) ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
  endfunction

  function automatic logic [63:0] m_word(input int w, input logic [2:0] idx);
    logic [7:0] wc;
    wc = (w == 0) ? 8'd48 : 8'd8;
    if (idx < 3'd4) m_word = m_cnt[w][idx[1:0]];
    else if (idx == 3'd4) m_word = {48'h0, wc, 4'h0, m_ovf[w]};
    else m_word = 64'h0;
  endfunction

  // Model: reads see the state before this edge; events count one edge late.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int w = 0; w < 2; w++) begin
          for (int i = 0; i < 4; i++) m_cnt[w][i] = 64'h0;
          m_ovf[w] = 4'h0;
        end
        m_pend = 4'h0;
        exp_q.delete();
      end else begin
        cyc++;
        if (csr_rd_en) begin
          r.due = cyc + 1;
          r.w48 = m_word(0, csr_rd_idx);
          r.w8  = m_word(1, csr_rd_idx);
          r.tid = csr_rd_tid;
          exp_q.push_back(r);
        end
        for (int w = 0; w < 2; w++) begin
          for (int i = 0; i < 4; i++) begin
            if (csr_wr_clear) begin
              m_cnt[w][i] = 64'h0;
              m_ovf[w][i] = 1'b0;
            end else if (m_pend[i]) begin
              if (m_cnt[w][i] == m_max(w)) m_ovf[w][i] = 1'b1;
              else m_cnt[w][i] = m_cnt[w][i] + 64'd1;
            end
          end
        end
        m_pend = wro_pipe_events;
      end
    end
  end

  // Compare process: every cycle out of reset, check valid and any response.
  initial begin
    logic ev;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("m_valid48", {63'b0, v48}, {63'b0, ev});
        chk("m_valid8",  {63'b0, v8},  {63'b0, ev});
        if (ev) begin
          chk("m_data48", d48, exp_q[0].w48);
          chk("m_data8",  d8,  exp_q[0].w8);
          chk("m_tid48",  {55'b0, t48}, {55'b0, exp_q[0].tid});
          chk("m_tid8",   {55'b0, t8},  {55'b0, exp_q[0].tid});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_resp(input string nm, input logic [8:0] tid,
                             input logic [63:0] e48, input logic [63:0] e8);
    chk({nm, "_v48"}, {63'b0, v48}, 64'd1);
    chk({nm, "_d48"}, d48, e48);
    chk({nm, "_t48"}, {55'b0, t48}, {55'b0, tid});
    chk({nm, "_v8"},  {63'b0, v8}, 64'd1);
    chk({nm, "_d8"},  d8, e8);
    chk({nm, "_t8"},  {55'b0, t8}, {55'b0, tid});
  endtask

  task automatic do_read(input string nm, input logic [2:0] idx, input logic [8:0] tid,
                         input logic [63:0] e48, input logic [63:0] e8);
    @(negedge clk);
    csr_rd_en = 1'b1; csr_rd_idx = idx; csr_rd_tid = tid;
    @(negedge clk);
    csr_rd_en = 1'b0;
    @(negedge clk);
    expect_resp(nm, tid, e48, e8);
  endtask

  task automatic pulse(input logic [3:0] ev, input int n);
    repeat (n) begin
      @(negedge clk);
      wro_pipe_events = ev;
    end
    @(negedge clk);
    wro_pipe_events = 4'b0000;
  endtask

  task automatic clear_all();
    @(negedge clk);
    csr_wr_clear = 1'b1;
    @(negedge clk);
    csr_wr_clear = 1'b0;
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_v48"}, {63'b0, v48}, 64'd0);
    chk({nm, "_d48"}, d48, 64'd0);
    chk({nm, "_t48"}, {55'b0, t48}, 64'd0);
    chk({nm, "_v8"},  {63'b0, v8}, 64'd0);
    chk({nm, "_d8"},  d8, 64'd0);
    chk({nm, "_t8"},  {55'b0, t8}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset_state");

    // Reset values of every word, tid echo
    for (int i = 0; i < 4; i++) do_read("rst_cnt", 3'(i), 9'h1A5, 64'h0, 64'h0);
    do_read("rst_status", 3'd4, 9'h1A5, 64'h3000, 64'h0800);

    // Basic count: rr x5, ww x3
    pulse(4'b1001, 3);
    pulse(4'b0001, 2);
    repeat (2) @(negedge clk);
    do_read("basic_rr", 3'd0, 9'h011, 64'd5, 64'd5);
    do_read("basic_ww", 3'd3, 9'h012, 64'd3, 64'd3);
    do_read("basic_rw", 3'd1, 9'h013, 64'd0, 64'd0);
    do_read("basic_status", 3'd4, 9'h014, 64'h3000, 64'h0800);

    // Simultaneous events then back-to-back reads
    clear_all();
    pulse(4'b1111, 10);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        chk("b2b_valid48", {63'b0, v48}, 64'd1);
        chk("b2b_data48", d48, 64'd10);
        chk("b2b_data8",  d8,  64'd10);
        chk("b2b_tid", {55'b0, t48}, {55'b0, 9'(9'h100 + k - 2)});
      end
      if (k < 4) begin
        csr_rd_en = 1'b1; csr_rd_idx = 3'(k); csr_rd_tid = 9'(9'h100 + k);
      end else begin
        csr_rd_en = 1'b0;
      end
    end

    // Saturation: wr x300
    clear_all();
    pulse(4'b0100, 300);
    @(negedge clk);
    do_read("sat_wr", 3'd2, 9'h021, 64'd300, 64'd255);
    do_read("sat_status", 3'd4, 9'h022, 64'h3000, 64'h0804);

    // Clear priority with a read in the clear cycle and an event in ev_q
    clear_all();
    pulse(4'b1000, 4);
    @(negedge clk);
    wro_pipe_events = 4'b1000;
    @(negedge clk);
    wro_pipe_events = 4'b0000;
    csr_wr_clear = 1'b1; csr_rd_en = 1'b1; csr_rd_idx = 3'd3; csr_rd_tid = 9'h033;
    @(negedge clk);
    csr_wr_clear = 1'b0; csr_rd_tid = 9'h034;
    @(negedge clk);
    csr_rd_en = 1'b0;
    expect_resp("clr_old", 9'h033, 64'd4, 64'd4);
    @(negedge clk);
    expect_resp("clr_new", 9'h034, 64'd0, 64'd0);
    do_read("clr_status", 3'd4, 9'h035, 64'h3000, 64'h0800);

    // Reset while a read is in flight
    pulse(4'b0010, 2);
    @(negedge clk);
    csr_rd_en = 1'b1; csr_rd_idx = 3'd1; csr_rd_tid = 9'h055;
    @(negedge clk);
    csr_rd_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_idle_zero("rst_midread");
    end
    do_read("post_rst_rw", 3'd1, 9'h056, 64'd0, 64'd0);

    // Reserved indices
    do_read("rsvd6", 3'd6, 9'h0FF, 64'h0, 64'h0);
    do_read("rsvd5", 3'd5, 9'h0A0, 64'h0, 64'h0);
    do_read("rsvd7", 3'd7, 9'h0A1, 64'h0, 64'h0);

    // Random phase A: heavy events, rare clears (drives 8-bit saturation)
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      wro_pipe_events = 4'($urandom);
      csr_rd_en    = 1'($urandom_range(0, 1));
      csr_rd_idx   = 3'($urandom);
      csr_rd_tid   = 9'($urandom);
      csr_wr_clear = ($urandom_range(0, 999) == 0);
    end
    // Random phase B: frequent clears
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      wro_pipe_events = 4'($urandom);
      csr_rd_en    = 1'($urandom_range(0, 1));
      csr_rd_idx   = 3'($urandom);
      csr_rd_tid   = 9'($urandom);
      csr_wr_clear = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    wro_pipe_events = 4'b0000; csr_rd_en = 1'b0; csr_wr_clear = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
